dmem_responder: RTL

- Data-memory responder: the slave end of the datapath's memory port.
- Receives word-addressed read/write requests (Address, WriteData) from the datapath and returns ReadData.
- Models a fixed, parameterised access latency with a one-cycle Ready pulse, so the controller can stall the datapath during an access.
- Sits between the datapath and the top-level simulator; replaces a combinational memory.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_array.sv | 19 +
 rtl/dmem_responder.sv | 86 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM type, op encoding and latency-counter width for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int   LAT_W    = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port RAM, registered read every cycle, no reset
module dmem_array #(
  parameter int NBITS = 8,
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata
);
  logic [NBITS-1:0] r_mem [DEPTH];
  // write when enabled; the read port samples the addressed word on every edge
  always_ff @(posedge clock) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency memory slave with one-cycle Ready pulse; DMEM_BOUNDS_EN adds range checking and the Error port
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int DEPTH   = 2 ** (NBITS - 2),
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:2] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             Ready,
  output logic             Busy
`ifdef DMEM_BOUNDS_EN
  ,
  output logic             Error
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = NBITS - 1;
  dmem_state_t      r_state;
  logic [LAT_W-1:0] r_cnt;
  logic [NBITS-1:2] r_addr;
  logic [NBITS-1:0] r_wdata;
  logic             r_op;
  logic [NBITS-1:2] w_addr;
  logic [AW-1:0]    w_idx;
  logic [NBITS-1:0] w_rdata;
  logic             w_oob;
  logic             w_access;
  logic             w_we;
  // In IDLE the RAM is addressed from the live request so that its registered
  // output already holds the word by the first WAIT edge, even with LATENCY=0.
  always_comb begin
    w_addr   = (r_state == IDLE) ? Address : r_addr;
    w_idx    = AW'({1'b0, w_addr} % XW'(DEPTH));
`ifdef DMEM_BOUNDS_EN
    w_oob    = {1'b0, r_addr} >= XW'(DEPTH);
`else
    w_oob    = 1'b0;
`endif
    w_access = (r_state == WAIT) && (r_cnt == '0);
    w_we     = w_access && (r_op == OP_WRITE) && !w_oob;
    Ready    = r_state == RESP;
    Busy     = r_state != IDLE;
`ifdef DMEM_BOUNDS_EN
    Error    = (r_state == RESP) && w_oob;
`endif
  end
  dmem_array #(.NBITS(NBITS), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clock(clock),
    .we   (w_we),
    .addr (w_idx),
    .wdata(r_wdata),
    .rdata(w_rdata)
  );
  // request acceptance, latency countdown, access and single-cycle response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_op     <= OP_READ;
      ReadData <= '0;
    end else if (r_state == IDLE) begin
      if (MemRead || MemWrite) begin
        r_state <= WAIT;
        r_cnt   <= LAT_W'(LATENCY);
        r_addr  <= Address;
        r_wdata <= WriteData;
        r_op    <= MemWrite ? OP_WRITE : OP_READ;
      end
    end else if (r_state == WAIT) begin
      if (r_cnt != '0) r_cnt <= r_cnt - LAT_W'(1);
      else begin
        r_state <= RESP;
        if (r_op == OP_READ) ReadData <= w_oob ? '0 : w_rdata;
      end
    end else r_state <= IDLE;
  end
endmodule
